// File: rtl/if_instr_queue_pkg.sv
// Shared constants, entry type and PC helper for the fetch-to-decode instruction queue.
package if_instr_queue_pkg;

  localparam int IFQ_DEPTH      = 4;
  localparam int IFQ_OUTST_MAX  = 2;
  localparam int BUS_DATA_INSTR = 32;
  localparam int BUS_ADDR_MEM   = 64;

  localparam logic [BUS_DATA_INSTR-1:0] ZERO_WORD   = '0;
  localparam logic [BUS_ADDR_MEM-1:0]   IFQ_BASE_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [BUS_DATA_INSTR-1:0] instr;
    logic [BUS_ADDR_MEM-1:0]   pc;
  } ifq_entry_t;

  // PC of the first instruction a beat contributes: bit 2 picks the start word.
  function automatic logic [BUS_ADDR_MEM-1:0] word_pc(input logic [BUS_ADDR_MEM-1:0] beat_pc);
    return {beat_pc[BUS_ADDR_MEM-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_credit.sv
// Tracks outstanding AR requests and stale responses after a redirect; grants fetch credit
// only when the queue can absorb every beat already requested plus one more.
module if_fetch_credit #(
  parameter int DEPTH     = 4,
  parameter int OUTST_MAX = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   ar_fire,
  input  logic                   beat_valid,
  input  logic                   beat_last,
  input  logic [$clog2(DEPTH):0] free,
  output logic                   fetch_en,
  output logic                   beat_live
);

  localparam int CW = $clog2(OUTST_MAX + 1);

  logic [CW-1:0] outst_cnt;
  logic [CW-1:0] drop_cnt;
  logic          beat_end;

  assign beat_end  = beat_valid & beat_last;
  assign beat_live = beat_valid & (drop_cnt == '0) & !flush;

  // Each outstanding request may return up to two instructions.
  assign fetch_en = !rst && (32'(outst_cnt) < OUTST_MAX) &&
                    (32'(free) >= 2 * (32'(outst_cnt) + 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      outst_cnt <= outst_cnt + CW'(ar_fire) - CW'(beat_end);
      // A request issued in the flush cycle belongs to the new path, so it is not dropped.
      if (flush)
        drop_cnt <= outst_cnt - CW'(beat_end);
      else if (beat_end && (drop_cnt != '0))
        drop_cnt <= drop_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/if_instr_queue.sv
// Fetch-to-decode buffer: splits 64-bit read beats into PC-tagged 32-bit instructions and
// presents them first-word fall-through with a valid/ready handshake.
module if_instr_queue
  import if_instr_queue_pkg::*;
#(
  parameter int                      DEPTH     = IFQ_DEPTH,
  parameter int                      OUTST_MAX = IFQ_OUTST_MAX,
  parameter logic [BUS_ADDR_MEM-1:0] BASE_PC   = IFQ_BASE_PC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      ar_fire,
  output logic                      fetch_en,
  input  logic                      beat_valid,
  input  logic                      beat_last,
  input  logic [63:0]               beat_data,
  input  logic [BUS_ADDR_MEM-1:0]   beat_pc,
  output logic                      instr_valid,
  output logic [BUS_DATA_INSTR-1:0] instr,
  output logic [BUS_ADDR_MEM-1:0]   instr_pc,
  input  logic                      instr_ready
);

  // Handshake: an entry transfers to decode on every rising edge where instr_valid and
  // instr_ready are both high; instr/instr_pc are stable while instr_valid is held.

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  ifq_entry_t              mem [DEPTH];
  ifq_entry_t              head;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           count;
  logic [PW-1:0]           free;
  logic [PW-1:0]           need;
  logic [AW-1:0]           wa0;
  logic [AW-1:0]           wa1;
  logic [BUS_ADDR_MEM-1:0] pc0;
  logic [BUS_ADDR_MEM-1:0] last_pc;
  logic                    beat_live;
  logic                    has_space;
  logic                    do_push;
  logic                    do_pop;

  if_fetch_credit #(
    .DEPTH     (DEPTH),
    .OUTST_MAX (OUTST_MAX)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .ar_fire    (ar_fire),
    .beat_valid (beat_valid),
    .beat_last  (beat_last),
    .free       (free),
    .fetch_en   (fetch_en),
    .beat_live  (beat_live)
  );

  assign count     = wr_ptr - rd_ptr;
  assign free      = PW'(DEPTH) - count;
  assign pc0       = word_pc(beat_pc);
  assign need      = beat_pc[2] ? PW'(1) : PW'(2);
  assign has_space = free >= need;
  assign do_push   = beat_live & has_space;
  assign do_pop    = instr_valid & instr_ready & !flush;
  assign wa0       = wr_ptr[AW-1:0];
  assign wa1       = wa0 + 1'b1;

  assign head        = mem[rd_ptr[AW-1:0]];
  assign instr_valid = !rst && (count != '0);
  assign instr       = instr_valid ? head.instr : ZERO_WORD;
  assign instr_pc    = rst ? BASE_PC : (instr_valid ? head.pc : last_pc);

  always_ff @(posedge clk) begin
    if (do_push) begin
      if (beat_pc[2]) begin
        mem[wa0] <= {beat_data[63:32], pc0};
      end else begin
        mem[wa0] <= {beat_data[31:0], pc0};
        mem[wa1] <= {beat_data[63:32], pc0 + 64'd4};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      last_pc <= BASE_PC;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + need;
      // No push can happen in a flush cycle, so the current wr_ptr is the new head.
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        last_pc <= head.pc;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(beat_live && !has_space));
  a_pc_aligned:  assert property (@(posedge clk) disable iff (rst) !beat_valid || (beat_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_if_instr_queue.sv
// Self-checking bench for if_instr_queue: queue-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_instr_queue;

  localparam int          DEPTH     = 4;
  localparam int          OUTST_MAX = 2;
  localparam logic [63:0] BASE_PC   = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ar_fire = 1'b0;
  logic        beat_valid = 1'b0;
  logic        beat_last = 1'b0;
  logic [63:0] beat_data = '0;
  logic [63:0] beat_pc = '0;
  logic        instr_ready = 1'b0;
  logic        fetch_en;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  // clock / reset block
  always #5 clk = ~clk;

  if_instr_queue dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .ar_fire     (ar_fire),
    .fetch_en    (fetch_en),
    .beat_valid  (beat_valid),
    .beat_last   (beat_last),
    .beat_data   (beat_data),
    .beat_pc     (beat_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  int checks = 0;
  int passed = 0;
  logic cmp_en = 1'b0;

  // Reference model: expected queue contents {instr, pc}, plus request bookkeeping.
  logic [95:0] exp_q[$];
  int          m_outst = 0;
  int          m_drop = 0;
  logic [63:0] m_last_pc = BASE_PC;

  function automatic logic model_fetch_en(input logic r);
    return !r && (m_outst < OUTST_MAX) && ((DEPTH - exp_q.size()) >= 2 * (m_outst + 1));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    int          old_size;
    int          bl;
    logic        live;
    logic [63:0] pc;
    if (rst) begin
      exp_q.delete();
      m_outst   = 0;
      m_drop    = 0;
      m_last_pc = BASE_PC;
    end else begin
      bl       = (beat_valid && beat_last) ? 1 : 0;
      live     = beat_valid && (m_drop == 0) && !flush;
      old_size = exp_q.size();
      pc       = {beat_pc[63:2], 2'b00};
      if (flush) begin
        exp_q.delete();
      end else if (instr_ready && old_size != 0) begin
        m_last_pc = exp_q[0][63:0];
        void'(exp_q.pop_front());
      end
      if (live) begin
        if (beat_pc[2]) begin
          if (DEPTH - old_size >= 1) exp_q.push_back({beat_data[63:32], pc});
        end else if (DEPTH - old_size >= 2) begin
          exp_q.push_back({beat_data[31:0], pc});
          exp_q.push_back({beat_data[63:32], pc + 64'd4});
        end
      end
      if (flush) m_drop = m_outst - bl;
      else if (bl == 1 && m_drop != 0) m_drop = m_drop - 1;
      m_outst = m_outst + (ar_fire ? 1 : 0) - bl;
    end
  end

  // Compare process: outputs are meaningful every cycle, including during reset.
  always @(negedge clk) begin
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    if (cmp_en) begin
      e_valid = !rst && (exp_q.size() != 0);
      e_instr = e_valid ? exp_q[0][95:64] : 32'h0;
      e_pc    = rst ? BASE_PC : (e_valid ? exp_q[0][63:0] : m_last_pc);
      check("cyc_instr_valid", 64'(instr_valid), 64'(e_valid));
      check("cyc_instr", 64'(instr), 64'(e_instr));
      check("cyc_instr_pc", instr_pc, e_pc);
      check("cyc_fetch_en", 64'(fetch_en), 64'(model_fetch_en(rst)));
    end
  end

  // driver tasks
  task automatic drive(input logic r, input logic f, input logic a, input logic bv,
                       input logic bl, input logic [63:0] d, input logic [63:0] p,
                       input logic rdy);
    rst = r; flush = f; ar_fire = a; beat_valid = bv; beat_last = bl;
    beat_data = d; beat_pc = p; instr_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, rdy);
  endtask

  task automatic req(input logic rdy);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, rdy);
  endtask

  task automatic beat(input logic [63:0] d, input logic [63:0] p, input logic rdy);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, d, p, rdy);
  endtask

  task automatic random_traffic(input int n);
    logic        r, f, a, bv, bl, rdy;
    logic [63:0] p, d;
    for (int i = 0; i < n; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      f   = !r && ($urandom_range(0, 15) == 0);
      a   = model_fetch_en(r) && ($urandom_range(0, 1) == 1);
      bv  = !r && (m_outst > 0) && ($urandom_range(0, 1) == 1);
      bl  = (m_drop > 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = ($urandom_range(0, 3) != 0);
      d   = {$urandom(), $urandom()};
      if ($urandom_range(0, 9) == 0) p = 64'hFFFF_FFFF_FFFF_FFF8;
      else p = {$urandom(), $urandom()};
      p[1:0] = 2'b00;
      p[2]   = 1'($urandom_range(0, 1));
      drive(r, f, a, bv, bl, d, p, rdy);
    end
  endtask

  initial begin
    // 1a. initial reset and release
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    cmp_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    check("rst_fetch_en", 64'(fetch_en), 64'd0);
    check("rst_instr_pc", instr_pc, BASE_PC);
    idle(1'b0);
    check("rel_fetch_en", 64'(fetch_en), 64'd1);
    check("rel_valid", 64'(instr_valid), 64'd0);

    // 2. aligned beat yields two instructions
    req(1'b0);
    beat(64'h00200093_00100093, 64'h8000_0000, 1'b0);
    check("al_valid", 64'(instr_valid), 64'd1);
    check("al_instr0", 64'(instr), 64'h0010_0093);
    check("al_pc0", instr_pc, 64'h8000_0000);
    idle(1'b1);
    check("al_instr1", 64'(instr), 64'h0020_0093);
    check("al_pc1", instr_pc, 64'h8000_0004);
    idle(1'b1);
    check("al_empty", 64'(instr_valid), 64'd0);
    check("al_zero_instr", 64'(instr), 64'd0);
    check("al_last_pc", instr_pc, 64'h8000_0004);

    // 3. odd start yields a single instruction
    req(1'b0);
    beat(64'hAAAAAAAA_BBBBBBBB, 64'h8000_0004, 1'b0);
    check("odd_instr", 64'(instr), 64'hAAAA_AAAA);
    check("odd_pc", instr_pc, 64'h8000_0004);
    idle(1'b1);
    check("odd_single", 64'(instr_valid), 64'd0);

    // 4. backpressure: credit closes, nothing lost, in-order drain
    req(1'b0);
    check("bp_fe_after1", 64'(fetch_en), 64'd1);
    req(1'b0);
    check("bp_fe_after2", 64'(fetch_en), 64'd0);
    beat(64'h00000002_00000001, 64'h1000, 1'b0);
    check("bp_fe_beat1", 64'(fetch_en), 64'd0);
    beat(64'h00000004_00000003, 64'h1008, 1'b0);
    check("bp_fe_full", 64'(fetch_en), 64'd0);
    for (int k = 0; k < 4; k++) begin
      check("bp_drain_instr", 64'(instr), 64'(k + 1));
      check("bp_drain_pc", instr_pc, 64'h1000 + 64'(4 * k));
      idle(1'b1);
    end
    check("bp_drained", 64'(instr_valid), 64'd0);
    check("bp_fe_reopen", 64'(fetch_en), 64'd1);

    // 5. flush with two outstanding: both stale beats dropped, next one kept
    req(1'b0);
    req(1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
    beat(64'h12345678_9ABCDEF0, 64'h2000, 1'b0);
    check("fl_drop1", 64'(instr_valid), 64'd0);
    beat(64'h0FEDCBA9_87654321, 64'h2008, 1'b0);
    check("fl_drop2", 64'(instr_valid), 64'd0);
    req(1'b0);
    beat(64'h55555555_66666666, 64'h3000, 1'b0);
    check("fl_kept_instr", 64'(instr), 64'h6666_6666);
    check("fl_kept_pc", instr_pc, 64'h3000);
    idle(1'b1);
    idle(1'b1);

    // 6a. flush coincident with ar_fire and beat_last: new request's beat accepted
    req(1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hDEADDEAD_DEADDEAD, 64'h2010, 1'b1);
    check("cr_flush_empty", 64'(instr_valid), 64'd0);
    beat(64'h77777777_88888888, 64'h4000, 1'b0);
    check("cr_accept_instr", 64'(instr), 64'h8888_8888);
    check("cr_accept_pc", instr_pc, 64'h4000);
    idle(1'b1);
    idle(1'b1);

    // 6b. pop asserted in the flush cycle has no effect on the last popped PC
    req(1'b0);
    beat(64'h99999999_00000000, 64'h5004, 1'b0);
    req(1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'hCAFECAFE_CAFECAFE, 64'h2020, 1'b1);
    check("cr_pop_ignored_valid", 64'(instr_valid), 64'd0);
    check("cr_pop_ignored_pc", instr_pc, 64'h4004);
    req(1'b0);
    beat(64'hABCDEF01_23456789, 64'h6000, 1'b0);
    check("cr_after_pc", instr_pc, 64'h6000);
    idle(1'b1);
    idle(1'b1);

    // randomized traffic, then reset held 3 cycles mid-traffic
    random_traffic(3000);
    random_traffic(50);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
    check("mid_rst_valid", 64'(instr_valid), 64'd0);
    check("mid_rst_fe", 64'(fetch_en), 64'd0);
    check("mid_rst_pc", instr_pc, BASE_PC);
    idle(1'b0);
    check("mid_rel_fe", 64'(fetch_en), 64'd1);
    check("mid_rel_empty", 64'(instr_valid), 64'd0);
    random_traffic(500);

    // final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
